mips_ifetch: RTL and testbench

Instruction fetch/issue unit and the producer side of the CPU's Instruction input. It holds the program counter and issues sequential word reads to instruction memory. Returned words are buffered in a small FIFO and presented to the CPU core as a 32-bit Instruction with a valid/ready handshake. A redirect port (branch/jump target) flushes the buffered and in-flight fetches and restarts fetch at a new PC.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/ifetch_fifo.sv | 70 +++++++
 rtl/mips_ifetch.sv | 107 ++++++++++
 tb/tb_mips_ifetch.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants and types: instruction/PC widths, the fetch
// stride, the default reset vector and the opcode field widths used by the decoder.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0] PC_INC           = 32'd4;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int JADDR_W  = 26;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [PC_W-1:0]    pc_t;

    function automatic pc_t word_align(input pc_t addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding fetched instruction words; flush empties it in one
// cycle and takes priority over push and pop.
module ifetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/mips_ifetch.sv
// Instruction fetch unit: issues sequential word reads, buffers in-order returns and
// hands them to the core; a redirect flushes everything and discards stale returns.
module mips_ifetch
    import mips_pkg::*;
#(
    parameter int        DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int INF_W = $clog2(2 * DEPTH + 1);
    localparam int OCC_W = INF_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    pc_t              pc_q, pc_d;
    pc_t              head_pc_q, head_pc_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [INF_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [INF_W-1:0] live;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] fifo_count;
    instr_t           fifo_head;
    logic             rvalid_ok, pop, issue, fifo_push;

    assign instr_valid = (fifo_count != '0);

    // Occupancy counts every word that will eventually land in the FIFO, so issuing
    // only below DEPTH means the FIFO can never overflow and memory needs no stall.
    always_comb begin
        rvalid_ok  = imem_rvalid && (inflight_q != '0);
        pop        = instr_valid && instr_ready && !redirect_valid;
        live       = inflight_q - drop_cnt_q;
        occupancy  = OCC_W'(live) + OCC_W'(fifo_count) - OCC_W'(pop);
        issue      = !RST && !redirect_valid && (occupancy < OCC_W'(DEPTH));
        fifo_push  = rvalid_ok && !redirect_valid && (drop_cnt_q == '0);

        pc_d       = pc_q;
        head_pc_d  = head_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = word_align(redirect_pc);
            head_pc_d  = word_align(redirect_pc);
            inflight_d = inflight_q - INF_W'(rvalid_ok);
            drop_cnt_d = inflight_q - INF_W'(rvalid_ok);
        end else begin
            if (issue) begin
                pc_d = pc_q + PC_INC;
            end
            if (pop) begin
                head_pc_d = head_pc_q + PC_INC;
            end
            inflight_d = inflight_q + INF_W'(issue) - INF_W'(rvalid_ok);
            if (rvalid_ok && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q       <= RESET_PC;
            head_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            head_pc_q  <= head_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (imem_rdata),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        imem_req    = issue;
        imem_addr   = issue ? pc_q : '0;
        Instruction = instr_valid ? fifo_head : '0;
        instr_pc    = head_pc_q;
    end

endmodule

// File: tb/tb_mips_ifetch.sv
// Bench for mips_ifetch: an in-order memory model plus a queue-based reference of
// what the fetch unit should present, driven by directed scenarios and random traffic.
module tb_mips_ifetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    mips_ifetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .Instruction    (Instruction),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    // Outstanding memory reads in request order; stale marks reads a redirect orphaned.
    req_t        mem_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_head = RESET_PC;
    logic [31:0] salt = 32'h0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          last_due = 0;
    int          cyc = 0;

    int checks = 0;
    int failures = 0;

    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_instr, obs_ipc;
    bit          exp_req, exp_valid;
    logic [31:0] exp_addr, exp_instr, exp_ipc;

    // One clock cycle: drive inputs, sample outputs mid-cycle, form the reference
    // expectation from the pre-edge model state, then advance model and clock.
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
        int   live;
        bit   pop;
        req_t ent;
        int   due;
        RST            = rst;
        redirect_valid = redir;
        redirect_pc    = redir ? rpc : 32'h0;
        instr_ready    = rdy;
        if (!rst && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr ^ salt;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_instr = Instruction;
        obs_ipc   = instr_pc;

        live = 0;
        foreach (mem_q[i]) if (!mem_q[i].stale) live++;
        pop       = (fifo_q.size() != 0) && rdy && !redir;
        exp_req   = !rst && !redir && ((live + fifo_q.size() - int'(pop)) < DEPTH);
        exp_addr  = exp_req ? m_pc : 32'h0;
        exp_valid = (fifo_q.size() != 0);
        exp_instr = exp_valid ? fifo_q[0] : 32'h0;
        exp_ipc   = m_head;

        if (rst) begin
            mem_q.delete();
            fifo_q.delete();
            m_pc     = RESET_PC;
            m_head   = RESET_PC;
            last_due = 0;
        end else begin
            if (imem_rvalid) begin
                ent = mem_q.pop_front();
                if (!redir && !ent.stale) fifo_q.push_back(imem_rdata);
            end
            if (redir) begin
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                fifo_q.delete();
                m_pc   = rpc & 32'hFFFF_FFFC;
                m_head = rpc & 32'hFFFF_FFFC;
            end else begin
                if (pop) begin
                    void'(fifo_q.pop_front());
                    m_head = m_head + 32'd4;
                end
                if (exp_req) begin
                    due = cyc + $urandom_range(lat_max, lat_min);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mem_q.push_back('{addr: m_pc, due: due, stale: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; salt = 32'h0;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", obs_req); end
        checks++;
        if (obs_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", obs_valid); end
        checks++;
        if (obs_instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=0", obs_instr); end
        checks++;
        if (obs_ipc !== RESET_PC) begin failures++; $display("[TB] FAIL reset_ipc got=%h exp=%h", obs_ipc, RESET_PC); end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            failures++; $display("[TB] FAIL reset_first_req req=%b addr=%h exp req=1 addr=%h", obs_req, obs_addr, RESET_PC);
        end
    endtask

    task automatic test_streaming();
        lat_min = 1; lat_max = 1; salt = 32'h0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== 32'(4 * k)) begin
                failures++; $display("[TB] FAIL stream_addr k=%0d req=%b addr=%h exp=%h", k, obs_req, obs_addr, 32'(4 * k));
            end
            if (k >= 2) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_ipc !== 32'(4 * (k - 2)) || obs_instr !== 32'(4 * (k - 2))) begin
                    failures++;
                    $display("[TB] FAIL stream_instr k=%0d valid=%b pc=%h instr=%h exp=%h", k, obs_valid, obs_ipc, obs_instr, 32'(4 * (k - 2)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int  nreq;
        int  npop;
        lat_min = 1; lat_max = 1; salt = 32'h0;
        do_reset();
        nreq = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (obs_req === 1'b1) begin
                checks++;
                if (obs_addr !== 32'(4 * nreq)) begin
                    failures++; $display("[TB] FAIL bp_addr got=%h exp=%h", obs_addr, 32'(4 * nreq));
                end
                nreq++;
            end
        end
        checks++;
        if (nreq != 4) begin failures++; $display("[TB] FAIL bp_fetch_count got=%0d exp=4", nreq); end
        checks++;
        if (obs_req !== 1'b0) begin failures++; $display("[TB] FAIL bp_stalled_req got=%b exp=0", obs_req); end
        npop = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (k == 0) begin
                checks++;
                if (obs_req !== 1'b1 || obs_addr !== 32'h10) begin
                    failures++; $display("[TB] FAIL bp_resume req=%b addr=%h exp addr=00000010", obs_req, obs_addr);
                end
            end
            if (obs_valid === 1'b1) begin
                checks++;
                if (obs_ipc !== 32'(4 * npop) || obs_instr !== 32'(4 * npop)) begin
                    failures++; $display("[TB] FAIL bp_order pc=%h instr=%h exp=%h", obs_ipc, obs_instr, 32'(4 * npop));
                end
                npop++;
            end
        end
        checks++;
        if (npop != 16) begin failures++; $display("[TB] FAIL bp_pop_count got=%0d exp=16", npop); end
    endtask

    task automatic test_redirect_inflight();
        bit found;
        int wait_n;
        lat_min = 3; lat_max = 3; salt = 32'h0;
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        found = 1'b0;
        wait_n = 0;
        for (int j = 1; j <= 20 && !found; j++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (obs_valid === 1'b1) begin found = 1'b1; wait_n = j; end
        end
        checks++;
        if (!found || wait_n != 5) begin
            failures++; $display("[TB] FAIL redir_first_valid found=%0d cycles=%0d exp cycles=5", found, wait_n);
        end
        checks++;
        if (obs_ipc !== 32'h100 || obs_instr !== 32'h100) begin
            failures++; $display("[TB] FAIL redir_first_instr pc=%h instr=%h exp=00000100", obs_ipc, obs_instr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_ipc !== 32'h104 || obs_instr !== 32'h104) begin
            failures++; $display("[TB] FAIL redir_second_instr valid=%b pc=%h instr=%h exp=00000104", obs_valid, obs_ipc, obs_instr);
        end
    endtask

    task automatic test_redirect_collision();
        lat_min = 1; lat_max = 1; salt = 32'h0;
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_instr !== 32'h0 || obs_req !== 1'b0) begin
            failures++; $display("[TB] FAIL coll_pre valid=%b instr=%h req=%b exp valid=1 instr=0 req=0", obs_valid, obs_instr, obs_req);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_valid !== 1'b0 || obs_instr !== 32'h0 || obs_ipc !== 32'h200) begin
            failures++; $display("[TB] FAIL coll_flushed valid=%b instr=%h pc=%h exp valid=0 instr=0 pc=00000200", obs_valid, obs_instr, obs_ipc);
        end
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin
            failures++; $display("[TB] FAIL coll_refetch req=%b addr=%h exp addr=00000200", obs_req, obs_addr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_ipc !== 32'h200 || obs_instr !== 32'h200) begin
            failures++; $display("[TB] FAIL coll_first_instr valid=%b pc=%h instr=%h exp=00000200", obs_valid, obs_ipc, obs_instr);
        end
    endtask

    task automatic test_reset_midstream();
        int npop;
        lat_min = 2; lat_max = 2; salt = 32'h5A5A_0000;
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_req !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_req got=%b exp=0", obs_req); end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_valid !== 1'b0 || obs_instr !== 32'h0 || obs_ipc !== RESET_PC) begin
            failures++; $display("[TB] FAIL mid_rst_state valid=%b instr=%h pc=%h exp 0/0/%h", obs_valid, obs_instr, obs_ipc, RESET_PC);
        end
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            failures++; $display("[TB] FAIL mid_rst_refetch req=%b addr=%h exp=%h", obs_req, obs_addr, RESET_PC);
        end
        npop = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (obs_valid === 1'b1) begin
                checks++;
                if (obs_ipc !== 32'(4 * npop) || obs_instr !== (32'(4 * npop) ^ salt)) begin
                    failures++; $display("[TB] FAIL mid_rst_order pc=%h instr=%h exp pc=%h", obs_ipc, obs_instr, 32'(4 * npop));
                end
                npop++;
            end
        end
        checks++;
        if (npop != 10) begin failures++; $display("[TB] FAIL mid_rst_pop_count got=%0d exp=10", npop); end
    endtask

    task automatic test_wrap();
        lat_min = 1; lat_max = 1; salt = 32'h0;
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
            failures++; $display("[TB] FAIL wrap_top_addr req=%b addr=%h exp=fffffffc", obs_req, obs_addr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            failures++; $display("[TB] FAIL wrap_addr req=%b addr=%h exp=00000000", obs_req, obs_addr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_ipc !== 32'hFFFF_FFFC || obs_instr !== 32'hFFFF_FFFC) begin
            failures++; $display("[TB] FAIL wrap_top_instr valid=%b pc=%h instr=%h exp=fffffffc", obs_valid, obs_ipc, obs_instr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_ipc !== 32'h0 || obs_instr !== 32'h0) begin
            failures++; $display("[TB] FAIL wrap_instr valid=%b pc=%h instr=%h exp=00000000", obs_valid, obs_ipc, obs_instr);
        end
    endtask

    task automatic test_random();
        bit rs, rd, rdy;
        lat_min = 1; lat_max = 4; salt = $urandom;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rs  = ($urandom_range(199, 0) == 0);
            rd  = ($urandom_range(99, 0) < 4);
            rdy = ($urandom_range(99, 0) < 70);
            step(rs, rd, $urandom, rdy);
            checks++;
            if (obs_req !== exp_req) begin
                failures++; $display("[TB] FAIL rand_req n=%0d got=%b exp=%b", n, obs_req, exp_req);
            end
            checks++;
            if (obs_addr !== exp_addr) begin
                failures++; $display("[TB] FAIL rand_addr n=%0d got=%h exp=%h", n, obs_addr, exp_addr);
            end
            checks++;
            if (obs_valid !== exp_valid) begin
                failures++; $display("[TB] FAIL rand_valid n=%0d got=%b exp=%b", n, obs_valid, exp_valid);
            end
            checks++;
            if (obs_instr !== exp_instr) begin
                failures++; $display("[TB] FAIL rand_instr n=%0d got=%h exp=%h", n, obs_instr, exp_instr);
            end
            checks++;
            if (obs_ipc !== exp_ipc) begin
                failures++; $display("[TB] FAIL rand_pc n=%0d got=%h exp=%h", n, obs_ipc, exp_ipc);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collision();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
